// File: rtl/tow_referee.sv
// Tug-of-war referee: turns two players' key presses into a moving one-hot
// light on an LED bar. Pulling the light off either end emits a one-cycle
// win pulse, darkens the bar for a fixed pause, then re-centres the light.
// A freeze from the score logic halts play until reset.
module tow_referee #(
    parameter int NUM_LEDS       = 9,
    parameter int RESTART_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_l,
    input  logic                key_r,
    input  logic                freeze,
    output logic [NUM_LEDS-1:0] leds,
    output logic                win_l,
    output logic                win_r
);

    localparam int POS_W  = $clog2(NUM_LEDS);
    localparam int RCNT_W = $clog2(RESTART_CYCLES + 1);

    localparam logic [POS_W-1:0]  CENTER   = POS_W'((NUM_LEDS - 1) / 2);
    localparam logic [POS_W-1:0]  LEFTMOST = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]  ONE_POS  = POS_W'(1);
    localparam logic [RCNT_W-1:0] RC_LAST  = RCNT_W'(RESTART_CYCLES - 1);
    localparam logic [RCNT_W-1:0] ONE_RC   = RCNT_W'(1);

    typedef enum logic [1:0] {
        PLAY,
        WIN,
        RESTART,
        HALT
    } state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              win_l_d, win_r_d;
    logic              key_l_q, key_r_q;
    logic              press_l, press_r;
    logic              move_l, move_r;

    // Previous key levels for rising-edge detection.
    // NOTE: these are sampled during reset as well, so a key held high across
    // reset release is seen as already pressed and produces no move.
    always_ff @(posedge clk) begin
        key_l_q <= key_l;
        key_r_q <= key_r;
    end

    assign press_l = key_l & ~key_l_q;
    assign press_r = key_r & ~key_r_q;

    // Simultaneous presses cancel each other out.
    assign move_l = press_l & ~press_r;
    assign move_r = press_r & ~press_l;

    // State, position, pause counter and win pulses.
    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PLAY;
            pos_q   <= CENTER;
            rcnt_q  <= '0;
            win_l   <= 1'b0;
            win_r   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            rcnt_q  <= rcnt_d;
            win_l   <= win_l_d;
            win_r   <= win_r_d;
        end
    end

    // Next-state logic for the referee FSM.
    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        rcnt_d  = rcnt_q;
        win_l_d = 1'b0;
        win_r_d = 1'b0;

        unique case (state_q)
            PLAY: begin
                if (freeze) begin
                    state_d = HALT;
                end else if (move_l) begin
                    if (pos_q == LEFTMOST) begin
                        state_d = WIN;
                        win_l_d = 1'b1;
                    end else begin
                        pos_d = pos_q + ONE_POS;
                    end
                end else if (move_r) begin
                    if (pos_q == '0) begin
                        state_d = WIN;
                        win_r_d = 1'b1;
                    end else begin
                        pos_d = pos_q - ONE_POS;
                    end
                end
            end

            WIN: begin
                state_d = RESTART;
                rcnt_d  = '0;
            end

            RESTART: begin
                if (freeze) begin
                    state_d = HALT;
                end else if (rcnt_q == RC_LAST) begin
                    state_d = PLAY;
                    pos_d   = CENTER;
                end else begin
                    rcnt_d = rcnt_q + ONE_RC;
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = PLAY;
                pos_d   = CENTER;
                rcnt_d  = '0;
            end
        endcase
    end

    // LED bar: lit only while playing, dark during pause and halt.
    always_comb begin
        leds = '0;
        if (state_q == PLAY) begin
            leds[pos_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_tow_referee.sv
// Self-checking bench for tow_referee: directed scenarios plus a randomized
// run, all compared against a behavioural model of the game rules.
module tb_tow_referee;

    localparam int N      = 9;
    localparam int RC     = 4;
    localparam int CENTER = (N - 1) / 2;

    logic         clk;
    logic         reset;
    logic         key_l;
    logic         key_r;
    logic         freeze;
    logic [N-1:0] leds;
    logic         win_l;
    logic         win_r;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: light position, remaining dark cycles, halted flag.
    int   m_pos    = CENTER;
    int   m_dark   = 0;
    bit   m_halt   = 1'b0;
    bit   m_wl     = 1'b0;
    bit   m_wr     = 1'b0;
    bit   m_prev_l = 1'b0;
    bit   m_prev_r = 1'b0;

    tow_referee #(
        .NUM_LEDS       (N),
        .RESTART_CYCLES (RC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_l  (key_l),
        .key_r  (key_r),
        .freeze (freeze),
        .leds   (leds),
        .win_l  (win_l),
        .win_r  (win_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] m_leds();
        logic [N-1:0] v;
        v = '0;
        if (!m_halt && m_dark == 0) v[m_pos] = 1'b1;
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs held in that cycle.
    task automatic model_step(input bit kl, input bit kr, input bit fz, input bit rs);
        bit pl;
        bit pr;
        pl = kl && !m_prev_l;
        pr = kr && !m_prev_r;
        m_prev_l = kl;
        m_prev_r = kr;
        m_wl = 1'b0;
        m_wr = 1'b0;
        if (rs) begin
            m_pos  = CENTER;
            m_dark = 0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            // halted: nothing changes until reset
        end else if (m_dark > 0) begin
            // the win cycle itself (m_dark == 1+RC) ignores freeze
            if (fz && m_dark < 1 + RC) begin
                m_halt = 1'b1;
                m_dark = 0;
            end else begin
                m_dark = m_dark - 1;
                if (m_dark == 0) m_pos = CENTER;
            end
        end else if (fz) begin
            m_halt = 1'b1;
        end else if (pl != pr) begin
            if (pl) begin
                if (m_pos == N - 1) begin
                    m_wl   = 1'b1;
                    m_dark = 1 + RC;
                end else begin
                    m_pos = m_pos + 1;
                end
            end else begin
                if (m_pos == 0) begin
                    m_wr   = 1'b1;
                    m_dark = 1 + RC;
                end else begin
                    m_pos = m_pos - 1;
                end
            end
        end
    endtask

    // Apply inputs for one cycle; returns at the following falling edge.
    task automatic tick(input bit kl, input bit kr, input bit fz, input bit rs);
        key_l  = kl;
        key_r  = kr;
        freeze = fz;
        reset  = rs;
        @(posedge clk);
        model_step(kl, kr, fz, rs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        n_checks++;
        if (leds !== 9'b000010000 || win_l !== 1'b0 || win_r !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: leds=%b win_l=%b win_r=%b, want leds=000010000 wins=0", leds, win_l, win_r);
        end
        tick(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0);
            n_checks++;
            if (leds !== 9'b000010000 || win_l !== 1'b0) begin
                n_errors++;
                $display("FAIL held_key_over_reset: leds=%b win_l=%b, want leds=000010000 win_l=0", leds, win_l);
            end
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_left_win();
        logic [N-1:0] steps [4];
        steps[0] = 9'b000100000;
        steps[1] = 9'b001000000;
        steps[2] = 9'b010000000;
        steps[3] = 9'b100000000;
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0, 0);
            n_checks++;
            if (leds !== steps[i] || leds !== m_leds()) begin
                n_errors++;
                $display("FAIL left_step%0d: leds=%b, want %b", i, leds, steps[i]);
            end
            tick(0, 0, 0, 0);
        end
        tick(1, 0, 0, 0);
        n_checks++;
        if (win_l !== 1'b1 || win_r !== 1'b0 || leds !== '0) begin
            n_errors++;
            $display("FAIL left_win_pulse: win_l=%b win_r=%b leds=%b, want 1 0 000000000", win_l, win_r, leds);
        end
        for (int i = 0; i < RC; i++) begin
            tick(0, 0, 0, 0);
            n_checks++;
            if (win_l !== 1'b0 || win_r !== 1'b0 || leds !== '0) begin
                n_errors++;
                $display("FAIL left_win_dark%0d: win_l=%b win_r=%b leds=%b, want 0 0 000000000", i, win_l, win_r, leds);
            end
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (leds !== 9'b000010000) begin
            n_errors++;
            $display("FAIL left_win_recentre: leds=%b, want 000010000", leds);
        end
    endtask

    task automatic test_hold_right();
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 0, 0);
            n_checks++;
            if (leds !== 9'b000001000) begin
                n_errors++;
                $display("FAIL hold_right_cycle%0d: leds=%b, want 000001000", i, leds);
            end
        end
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        n_checks++;
        if (leds !== 9'b000000100) begin
            n_errors++;
            $display("FAIL right_repress: leds=%b, want 000000100", leds);
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_cancel();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        n_checks++;
        if (leds !== 9'b000010000 || win_l !== 1'b0 || win_r !== 1'b0) begin
            n_errors++;
            $display("FAIL cancel_center: leds=%b wins=%b%b, want 000010000 00", leds, win_l, win_r);
        end
        tick(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0, 0);
            tick(0, 0, 0, 0);
        end
        tick(1, 1, 0, 0);
        n_checks++;
        if (leds !== 9'b100000000 || win_l !== 1'b0 || win_r !== 1'b0) begin
            n_errors++;
            $display("FAIL cancel_edge: leds=%b wins=%b%b, want 100000000 00", leds, win_l, win_r);
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (win_l !== 1'b0 || leds !== 9'b100000000) begin
            n_errors++;
            $display("FAIL cancel_edge_after: leds=%b win_l=%b, want 100000000 0", leds, win_l);
        end
    endtask

    task automatic test_freeze_halt();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 0);
            tick(0, 0, 0, 0);
        end
        tick(0, 1, 0, 0);
        n_checks++;
        if (win_r !== 1'b1 || win_l !== 1'b0) begin
            n_errors++;
            $display("FAIL right_win_pulse: win_l=%b win_r=%b, want 0 1", win_l, win_r);
        end
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            tick(i[0], i[1], 1'b0, 0);
            n_checks++;
            if (leds !== '0 || win_l !== 1'b0 || win_r !== 1'b0) begin
                n_errors++;
                $display("FAIL halt_cycle%0d: leds=%b wins=%b%b, want 000000000 00", i, leds, win_l, win_r);
            end
        end
        tick(0, 0, 0, 1);
        n_checks++;
        if (leds !== 9'b000010000) begin
            n_errors++;
            $display("FAIL halt_reset: leds=%b, want 000010000", leds);
        end
        tick(1, 0, 0, 0);
        n_checks++;
        if (leds !== 9'b000100000) begin
            n_errors++;
            $display("FAIL halt_resume: leds=%b, want 000100000", leds);
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_restart();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 0);
            tick(0, 0, 0, 0);
        end
        // now in the first RESTART cycle; one more reaches the second
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (leds !== 9'b000010000 || win_l !== 1'b0 || win_r !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid_restart%0d: leds=%b wins=%b%b, want 000010000 00", i, leds, win_l, win_r);
            end
            tick(0, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0, 0);
            tick(0, 0, 0, 0);
        end
        tick(1, 0, 1, 0);
        n_checks++;
        if (leds !== '0 || win_l !== 1'b0) begin
            n_errors++;
            $display("FAIL freeze_with_tap: leds=%b win_l=%b, want 000000000 0", leds, win_l);
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (leds !== '0 || win_l !== 1'b0) begin
            n_errors++;
            $display("FAIL freeze_with_tap_after: leds=%b win_l=%b, want 000000000 0", leds, win_l);
        end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_random();
        bit kl;
        bit kr;
        bit fz;
        bit rs;
        kl = 1'b0;
        kr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) kl = !kl;
            if ($urandom_range(0, 2) == 0) kr = !kr;
            fz = ($urandom_range(0, 149) == 0);
            rs = ($urandom_range(0, 79) == 0);
            tick(kl, kr, fz, rs);
            n_checks++;
            if (leds !== m_leds() || win_l !== m_wl || win_r !== m_wr) begin
                n_errors++;
                $display("FAIL random_cycle%0d: leds=%b win_l=%b win_r=%b, want leds=%b win_l=%b win_r=%b",
                         i, leds, win_l, win_r, m_leds(), m_wl, m_wr);
            end
        end
    endtask

    initial begin
        key_l  = 1'b0;
        key_r  = 1'b0;
        freeze = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        test_reset();
        test_left_win();
        test_hold_right();
        test_cancel();
        test_freeze_halt();
        test_reset_mid_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
